instruction_cache: RTL and testbench
====================================

# instruction_cache

Direct-mapped, read-only instruction cache between the PC register and the IF/ID pipeline register. It looks up the fetch PC combinationally and returns the instruction with `hit`. On a miss it runs a multi-beat block refill from the backing instruction memory. `hit` is the pipeline-wide advance enable: IF/ID, ID/EX, EX/MEM and MEM/WB hold their contents while it is low.

## Interface
- `LINES`, 8: number of cache lines; power of 2, ≥2. IDX = log2(LINES).
- `WORDS`, 4: 32-bit words per line; power of 2, ≥2. OFF = log2(WORDS).
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `pc`  in  32: fetch byte address; word-aligned, bits [1:0] ignored.
- `flush`  in  1: invalidate all lines (program reload).
- `instruction`  out  32: cached word at `pc` when `hit`=1; otherwise 32'h00000000 (NOP).
- `hit`  out  1: `instruction` is valid this cycle; pipeline advance enable.
- `mem_req`  out  1: refill request, held high for the whole refill.
- `mem_addr`  out  32: block-aligned refill address, stable while `mem_req`=1.
- `mem_rdata`  in  32: refill data beat.
- `mem_valid`  in  1: `mem_rdata` valid. Beats arrive in order, offset 0..WORDS-1, one per asserted cycle, gaps allowed.
- `miss_count`  out  16: number of refills started; wraps at 16'hFFFF→0.

## Operation
- Address split: offset = `pc`[OFF+1:2], index = `pc`[OFF+IDX+1:OFF+2], tag = `pc`[31:OFF+IDX+2].
- Storage: data array LINES×WORDS×32, tag array, valid bit per line. No reset on data or tag arrays.
- FSM states:
  - IDLE: `hit` = valid[index] & (tag match) & ~`flush`. On a miss with `flush`=0:
    - latch `mem_addr` = {`pc`[31:OFF+2], (OFF+2) zeros};
    - clear valid[index];
    - write tag[index];
    - zero the beat counter;
    - increment `miss_count`;
    - go to FILL.
  - FILL: `hit`=0 and `mem_req`=1.
    - Each `mem_valid` writes `mem_rdata` to data[line][counter] and increments the counter.
    - On the beat with counter = WORDS-1: set valid[line] unless a flush is pending, clear `mem_req`, return to IDLE.
- A refill always completes for the latched address. Changes on `pc` during FILL are ignored; the new `pc` is looked up after return to IDLE.
- `mem_valid` in IDLE is ignored.
- `flush`:
  - In IDLE: clears all valid bits at the edge; `hit`=0 in that cycle; no miss is started in that cycle.
  - In FILL: clears all valid bits and sets a pending flag. The refill completes, but the line is not validated. The pending flag clears on return to IDLE.
- No critical-word forwarding: data is returned only from the array.

## Timing
- Hit latency: 0 cycles; combinational from `pc`.
- Miss at cycle t (IDLE, `hit`=0): `mem_req`=1 and `mem_addr` valid from cycle t+1.
- Final beat accepted at edge e: `mem_req`=0 from the cycle after e; `hit`=1 in that same cycle if `pc` still maps to the refilled line.
- Miss penalty: 1 + (cycles until the last `mem_valid`) + 0 extra.
- Reset values, asynchronous:
  - state IDLE, all valid bits 0, counter 0, pending flag 0;
  - `mem_req`=0, `mem_addr`=0, `miss_count`=0;
  - hence `hit`=0 and `instruction`=0.
- Reset mid-FILL drops `mem_req` immediately. The partial line stays invalid.

## Test plan
- Cold miss, default parameters:
  - stimulus: reset, then `pc`=0x00000000;
  - `hit`=0, then `mem_req`=1 with `mem_addr`=0x00000000;
  - supply beats 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000 on consecutive cycles;
  - required: `hit`=1 with `instruction`=0x20080001 the cycle after the last beat;
  - then `pc`=0x0C → `hit`=1, 0xAC0A0000, same cycle; `miss_count`=1.
- Conflict eviction:
  - stimulus: after the cold miss, `pc`=0x00000080 (index 0, tag 1);
  - required: refill at `mem_addr`=0x80;
  - then `pc`=0x0 misses again with `mem_addr`=0x0; `miss_count`=3.
- Beat gaps and PC change:
  - stimulus: miss on 0x40; `mem_valid` asserted every other cycle; `pc` switched to 0x100 during FILL;
  - required: line 0x40 filled correctly and marked valid;
  - then 0x100 misses with `mem_addr`=0x100; a later access to 0x44 hits.
- Flush:
  - stimulus: `flush` pulse while in FILL for 0x20;
  - required: the refill completes (`mem_req` drops after 4 beats), but 0x20 then misses again and 0x0 misses;
  - stimulus: `flush` in IDLE while `pc`=0x0 is cached;
  - required: `hit`=0 that cycle, miss the next cycle.
- Reset mid-FILL:
  - stimulus: `reset` asserted after 2 beats;
  - required: `mem_req`=0 and `miss_count`=0 asynchronously;
  - after release, `pc`=0x0 misses and refills from beat 0.
- Counter wrap:
  - stimulus: preload by forcing 65535 misses (or parameterized fast path), then one more miss;
  - required: `miss_count`=0.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache.
// A hit is resolved combinationally from pc. A miss refills the whole block
// from the backing memory, one beat per mem_valid, offsets 0..WORDS-1.
// hit doubles as the pipeline advance enable.
module instruction_cache #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic [15:0] miss_count
);
    localparam int IDX  = $clog2(LINES);
    localparam int OFF  = $clog2(WORDS);
    localparam int TAGW = 32 - IDX - OFF - 2;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state, state_nxt;

    // Storage: data and tags carry no reset, only the valid bits do.
    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tag_arr  [LINES];
    logic [31:0]      data_arr [LINES*WORDS];

    // Refill bookkeeping.
    logic [OFF-1:0]   cnt;
    logic             pend;

    // Decoded fetch address.
    logic [OFF-1:0]   pc_off;
    logic [IDX-1:0]   pc_idx;
    logic [TAGW-1:0]  pc_tag;
    logic [IDX-1:0]   fill_idx;

    // Per-cycle control strobes from the FSM.
    logic             miss_start;
    logic             beat;
    logic             last_beat;

    // pc[1:0] is ignored: fetches are word aligned.
    logic             unused_pc_lsb;
    assign unused_pc_lsb = ^pc[1:0];

    assign pc_off   = pc[OFF+1:2];
    assign pc_idx   = pc[OFF+IDX+1:OFF+2];
    assign pc_tag   = pc[31:OFF+IDX+2];
    // The line being refilled is named by the latched, block-aligned address.
    assign fill_idx = mem_addr[OFF+IDX+1:OFF+2];

    assign mem_req     = (state == FILL);
    assign instruction = hit ? data_arr[{pc_idx, pc_off}] : 32'h0000_0000;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, hit decision and refill strobes.
    always_comb begin
        state_nxt  = state;
        hit        = 1'b0;
        miss_start = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        case (state)
            IDLE: begin
                hit = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag) && !flush;
                // A flush cycle never starts a refill; the lookup retries next cycle.
                if (!hit && !flush) begin
                    miss_start = 1'b1;
                    state_nxt  = FILL;
                end
            end
            FILL: begin
                beat = mem_valid;
                // WORDS is a power of two, so an all-ones counter is the last offset.
                if (mem_valid && (&cnt)) begin
                    last_beat = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: valid bits, refill address/counter, flush-pending flag, miss counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            mem_addr   <= '0;
            miss_count <= '0;
        end else begin
            if (miss_start) begin
                mem_addr   <= {pc[31:OFF+2], {(OFF+2){1'b0}}};
                cnt        <= '0;
                miss_count <= miss_count + 16'd1;
            end else if (beat) begin
                cnt <= cnt + OFF'(1);
            end

            // Flush wins over everything, including a final beat in the same cycle.
            if (flush) begin
                valid <= '0;
            end else if (miss_start) begin
                valid[pc_idx] <= 1'b0;
            end else if (last_beat && !pend) begin
                valid[fill_idx] <= 1'b1;
            end

            // A flush seen mid-refill keeps the line invalid once the refill ends.
            if (last_beat) begin
                pend <= 1'b0;
            end else if ((state == FILL) && flush) begin
                pend <= 1'b1;
            end
        end
    end

    // Tag and data arrays: tag written when the refill starts, data per beat.
    always_ff @(posedge clk) begin
        if (miss_start) begin
            tag_arr[pc_idx] <= pc_tag;
        end
        if (beat) begin
            data_arr[{fill_idx, cnt}] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios followed by random fetches,
// checked against a line/tag model of a direct-mapped cache over a fixed memory image.
module tb_instruction_cache;
    localparam int LINES = 8;
    localparam int WORDS = 4;
    localparam int BLK_BYTES = WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instruction;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] miss_count;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit          m_valid [LINES];
    logic [31:0] m_blk   [LINES];
    logic [15:0] m_miss;
    logic [31:0] mem_img [logic [31:0]];

    instruction_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .flush(flush),
        .instruction(instruction),
        .hit(hit),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem_img.exists(w)) return mem_img[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] blk(input logic [31:0] a);
        return (a / BLK_BYTES) * BLK_BYTES;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a / BLK_BYTES) % LINES);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[line_of(a)] && (m_blk[line_of(a)] == blk(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One IDLE cycle presenting addr; returns whether the model expects a hit.
    task automatic lookup(input logic [31:0] addr, output bit was_hit);
        pc        = addr;
        flush     = 1'b0;
        mem_valid = 1'($urandom_range(1, 0));   // ignored in IDLE
        mem_rdata = $urandom;
        #1;
        chk("idle_req", 32'(mem_req), 32'd0);
        was_hit = m_hit(addr);
        if (was_hit) begin
            chk("hit", 32'(hit), 32'd1);
            chk("instr", instruction, word_at(addr));
        end else begin
            chk("miss", 32'(hit), 32'd0);
            chk("nop", instruction, 32'd0);
        end
        cyc();
        mem_valid = 1'b0;
        if (!was_hit) begin
            m_miss++;
            m_valid[line_of(addr)] = 1'b0;
            m_blk[line_of(addr)]   = blk(addr);
        end
    endtask

    // Supply nb beats of a refill for base, with gap_lo..gap_hi idle cycles before each.
    task automatic serve(input logic [31:0] base, input int nb, input int gap_lo, input int gap_hi,
                         input logic [31:0] pc_during, input int flush_beat);
        bit fl;
        int g;
        fl = 1'b0;
        pc = pc_during;
        #1;
        chk("req_up", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, base);
        chk("miss_cnt", 32'(miss_count), 32'(m_miss));
        for (int b = 0; b < nb; b++) begin
            g = int'($urandom_range(gap_hi, gap_lo));
            for (int k = 0; k < g; k++) begin
                mem_valid = 1'b0;
                mem_rdata = $urandom;
                flush     = 1'b0;
                #1;
                chk("gap_req", 32'(mem_req), 32'd1);
                chk("gap_hit", 32'(hit), 32'd0);
                cyc();
            end
            mem_valid = 1'b1;
            mem_rdata = word_at(base + 32'(4 * b));
            flush     = (b == flush_beat);
            #1;
            chk("beat_req", 32'(mem_req), 32'd1);
            chk("beat_hit", 32'(hit), 32'd0);
            if (flush) begin
                fl = 1'b1;
                model_clear();
            end
            cyc();
        end
        mem_valid = 1'b0;
        flush     = 1'b0;
        if (nb == WORDS) begin
            #1;
            chk("req_down", 32'(mem_req), 32'd0);
            if (!fl) m_valid[line_of(base)] = 1'b1;
        end
    endtask

    // Full fetch of addr: hit, or miss + refill + check in the cycle after the last beat.
    task automatic fetch(input logic [31:0] addr, input int gap_lo, input int gap_hi,
                         input logic [31:0] pc_during, input int flush_beat);
        bit h;
        lookup(addr, h);
        if (!h) begin
            serve(blk(addr), WORDS, gap_lo, gap_hi, pc_during, flush_beat);
            chk("post_hit", 32'(hit), 32'(m_hit(pc)));
            if (m_hit(pc)) chk("post_instr", instruction, word_at(pc));
        end
    endtask

    initial begin
        bit h;
        logic [31:0] a, alt;
        int fb;

        mem_img[32'h0] = 32'h2008_0001;
        mem_img[32'h4] = 32'h2009_0002;
        mem_img[32'h8] = 32'h0109_5020;
        mem_img[32'hC] = 32'hAC0A_0000;
        model_clear();
        for (int i = 0; i < LINES; i++) m_blk[i] = '0;
        m_miss = '0;

        // Reset state.
        reset = 1'b1; pc = 32'h0; flush = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_mc", 32'(miss_count), 32'd0);
        cyc(); cyc();
        reset = 1'b0;

        // Cold miss, then a same-line hit.
        fetch(32'h0, 0, 0, 32'h0, -1);
        chk("cold_instr", instruction, 32'h2008_0001);
        fetch(32'hC, 0, 0, 32'hC, -1);
        chk("cold_hitC", 32'(hit), 32'd1);
        chk("cold_wordC", instruction, 32'hAC0A_0000);
        chk("cold_mc", 32'(miss_count), 32'd1);

        // Conflict eviction on index 0.
        fetch(32'h80, 0, 0, 32'h80, -1);
        fetch(32'h0, 0, 0, 32'h0, -1);
        chk("evict_mc", 32'(miss_count), 32'd3);

        // Gapped beats with pc moved during the refill.
        fetch(32'h40, 1, 1, 32'h100, -1);
        fetch(32'h100, 0, 1, 32'h100, -1);
        fetch(32'h44, 0, 0, 32'h44, -1);
        chk("gap_44_hit", 32'(hit), 32'd1);

        // Flush during a refill of 0x20.
        fetch(32'h20, 0, 1, 32'h20, 1);
        lookup(32'h20, h);
        chk("flushfill_20", 32'(h), 32'd0);
        serve(32'h20, WORDS, 0, 0, 32'h20, -1);
        fetch(32'h0, 0, 0, 32'h0, -1);

        // Flush in IDLE while 0x0 is cached.
        pc = 32'h0; flush = 1'b1;
        #1;
        chk("iflush_hit", 32'(hit), 32'd0);
        chk("iflush_nop", instruction, 32'd0);
        cyc();
        model_clear();
        flush = 1'b0;
        #1;
        chk("iflush_noreq", 32'(mem_req), 32'd0);
        lookup(32'h0, h);
        chk("iflush_miss", 32'(h), 32'd0);
        serve(32'h0, WORDS, 0, 0, 32'h0, -1);

        // Asynchronous reset after two beats.
        lookup(32'h60, h);
        serve(32'h60, 2, 0, 0, 32'h60, -1);
        reset = 1'b1;
        #1;
        chk("rstfill_req", 32'(mem_req), 32'd0);
        chk("rstfill_mc", 32'(miss_count), 32'd0);
        chk("rstfill_hit", 32'(hit), 32'd0);
        cyc();
        reset = 1'b0;
        model_clear();
        m_miss = '0;
        fetch(32'h0, 0, 1, 32'h0, -1);
        fetch(32'h60, 0, 0, 32'h60, -1);

        // Random fetch traffic.
        for (int n = 0; n < 60; n++) begin
            a   = 32'($urandom_range(127, 0)) * 4;
            alt = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(127, 0)) * 4 : a;
            fb  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(WORDS - 1, 0)) : -1;
            fetch(a, 0, int'($urandom_range(2, 0)), alt, fb);
        end

        // Miss counter wrap.
        force dut.miss_count = 16'hFFFF;
        #1;
        release dut.miss_count;
        m_miss = 16'hFFFF;
        fetch(32'h3F0, 0, 0, 32'h3F0, -1);
        chk("wrap_mc", 32'(miss_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
